// File: rtl/fir_arb_pkg.sv
// Shared types and constants for the FIR Wishbone arbiter.
// Imported by the arbiter top and the round-robin picker.
package fir_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ABORT
  } arb_state_t;

  localparam int WD_W = 16;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_rr_picker.sv
// One-hot round-robin select: first requester at or after ptr,
// wrapping to index 0.
module fir_rr_picker
  import fir_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = ptr_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
    // wrap-around pass over the indices below ptr
    for (int j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one FIR slave among masters,
// with tenure-long grants and a stalled-strobe watchdog.
module fir_wb_arbiter
  import fir_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  input  logic                                s_err_i,
  output logic [NUM_MASTERS-1:0]              grant_o,
  output logic                                timeout_o
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int PTR_W = ptr_w(NUM_MASTERS);

  arb_state_t state_q, state_d;

  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
  logic [PTR_W-1:0]       ptr_q, ptr_d, g_idx, g_next;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic                  g_cyc, g_stb, g_we;
  logic [SW-1:0]         g_sel;
  logic [ADDR_WIDTH-1:0] g_adr;
  logic [DATA_WIDTH-1:0] g_dat;

  logic st_busy, st_abort, resp, stall, wd_hit;

  fir_rr_picker #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (m_cyc_i),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    g_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        g_cyc = m_cyc_i[k];
        g_stb = m_stb_i[k];
        g_we  = m_we_i[k];
        g_sel = m_sel_i[k*SW +: SW];
        g_adr = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        g_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        g_idx = PTR_W'(k);
      end
    end
  end

  assign g_next = (g_idx == PTR_W'(NUM_MASTERS - 1)) ?
                  '0 : g_idx + PTR_W'(1);

  assign st_busy  = (state_q == BUSY);
  assign st_abort = (state_q == ABORT);
  assign resp     = s_ack_i | s_err_i;
  assign stall    = st_busy & s_stb_o & ~resp;
  // abort on the edge where the stall count would reach the limit
  assign wd_hit   = stall &
                    (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_d     = stall ? wd_q + WD_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wd_hit) begin
          state_d = ABORT;
        end else if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = g_next;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = g_next;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // outputs are held low while reset is asserted
  assign s_cyc_o   = rst_ni & st_busy & g_cyc;
  assign s_stb_o   = rst_ni & st_busy & g_stb;
  assign s_we_o    = rst_ni & g_we;
  assign s_sel_o   = rst_ni ? g_sel : '0;
  assign s_adr_o   = rst_ni ? g_adr : '0;
  assign s_dat_o   = rst_ni ? g_dat : '0;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = (rst_ni && st_busy && s_ack_i) ?
                     grant_q : '0;
  assign m_err_o   = (rst_ni && ((st_busy && s_err_i) || st_abort)) ?
                     grant_q : '0;
  assign grant_o   = rst_ni ? grant_q : '0;
  assign timeout_o = rst_ni & st_abort;

endmodule

// File: tb/tb_fir_wb_arbiter.sv
// Bench for fir_wb_arbiter: directed master/slave traffic, a per-cycle
// reference model of the arbitration rules, and literal spot checks.
module tb_fir_wb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cyc_m [2];
  logic        stb_m [2];
  logic        we_m  [2];
  logic [31:0] adr_m [2];
  logic [31:0] dat_m [2];

  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*SW-1:0] m_sel_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [SW-1:0]   s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i;

  assign m_cyc_i = {cyc_m[1], cyc_m[0]};
  assign m_stb_i = {stb_m[1], stb_m[0]};
  assign m_we_i  = {we_m[1], we_m[0]};
  assign m_sel_i = 8'hFF;
  assign m_adr_i = {adr_m[1], adr_m[0]};
  assign m_dat_i = {dat_m[1], dat_m[0]};

  fir_wb_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_sel_i   (m_sel_i),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // slave: responds lat cycles after strobe is seen, lat<0 = never
  int lat      = 0;
  bit err_mode = 1'b0;
  int wcnt     = 0;

  initial begin
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_dat_i = 32'hFFFF_0000;
    forever begin
      @(posedge clk);
      #2;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_dat_i = 32'hFFFF_0000;
      if (s_cyc_o && s_stb_o && lat >= 0) begin
        if (wcnt == lat) begin
          wcnt    = 0;
          s_dat_i = s_adr_o ^ 32'hC0DE_0000;
          if (err_mode) s_err_i = 1'b1;
          else s_ack_i = 1'b1;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // reference model: owner, abort flag, rr pointer, stall count
  bit md_idle = 1'b1;
  bit md_own  = 1'b0;
  bit md_ab   = 1'b0;
  bit md_ptr  = 1'b0;
  int md_run  = 0;

  initial begin
    logic [1:0]  eg, eack, eerr;
    logic        ecyc, estb, ewe, eto;
    logic [3:0]  esel;
    logic [31:0] eadr, edat;
    forever begin
      @(negedge clk);
      eg = 2'b00; eack = 2'b00; eerr = 2'b00;
      ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; eto = 1'b0;
      esel = 4'h0; eadr = 32'h0; edat = 32'h0;
      if (rst_n && !md_idle) begin
        eg = md_own ? 2'b10 : 2'b01;
        if (md_ab) begin
          eerr = eg;
          eto  = 1'b1;
        end else begin
          ecyc = cyc_m[md_own];
          estb = stb_m[md_own];
          ewe  = we_m[md_own];
          esel = 4'hF;
          eadr = adr_m[md_own];
          edat = dat_m[md_own];
          eack = s_ack_i ? eg : 2'b00;
          eerr = s_err_i ? eg : 2'b00;
        end
      end
      chk("mdl_grant", 32'(grant_o), 32'(eg));
      chk("mdl_ack", 32'(m_ack_o), 32'(eack));
      chk("mdl_err", 32'(m_err_o), 32'(eerr));
      chk("mdl_timeout", 32'(timeout_o), 32'(eto));
      chk("mdl_s_cyc", 32'(s_cyc_o), 32'(ecyc));
      chk("mdl_s_stb", 32'(s_stb_o), 32'(estb));
      chk("mdl_m_dat", m_dat_o, s_dat_i);
      if (!(rst_n && md_ab)) begin
        chk("mdl_s_we", 32'(s_we_o), 32'(ewe));
        chk("mdl_s_sel", 32'(s_sel_o), 32'(esel));
        chk("mdl_s_adr", s_adr_o, eadr);
        chk("mdl_s_dat", s_dat_o, edat);
      end
      if (!rst_n) begin
        md_idle = 1'b1; md_ab = 1'b0; md_ptr = 1'b0; md_run = 0;
      end else if (md_idle) begin
        md_run = 0;
        if (cyc_m[md_ptr]) begin
          md_own = md_ptr; md_idle = 1'b0;
        end else if (cyc_m[~md_ptr]) begin
          md_own = ~md_ptr; md_idle = 1'b0;
        end
      end else if (md_ab) begin
        md_ptr = ~md_own; md_idle = 1'b1; md_ab = 1'b0; md_run = 0;
      end else begin
        if (stb_m[md_own] && !s_ack_i && !s_err_i) md_run++;
        else md_run = 0;
        if (md_run == TO) begin
          md_ab = 1'b1;
        end else if (!cyc_m[md_own]) begin
          md_ptr = ~md_own; md_idle = 1'b1; md_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive(input logic k, input logic c, input logic s,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    cyc_m[k] = c; stb_m[k] = s; we_m[k] = w;
    adr_m[k] = a; dat_m[k] = d;
  endtask

  logic [31:0] rd_adr [3];
  logic [31:0] rd_exp [3];

  initial begin
    rd_adr[0] = 32'h24; rd_exp[0] = 32'hC0DE_0024;
    rd_adr[1] = 32'h28; rd_exp[1] = 32'hC0DE_0028;
    rd_adr[2] = 32'h2C; rd_exp[2] = 32'hC0DE_002C;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); neg();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    tick(); rst_n = 1'b1;

    // single write by master 0, slave acks two cycles after strobe
    tick(); lat = 2;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hAA);
    neg(); chk("t1_grant_c0", 32'(grant_o), 32'h0);
    tick(); neg();
    chk("t1_grant_c1", 32'(grant_o), 32'h1);
    chk("t1_s_adr", s_adr_o, 32'h10);
    chk("t1_s_dat", s_dat_o, 32'hAA);
    tick(); neg(); chk("t1_ack_c2", 32'(m_ack_o), 32'h0);
    tick(); neg(); chk("t1_ack_c3", 32'(m_ack_o), 32'h1);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); chk("t1_ack_c4", 32'(m_ack_o), 32'h0);
    tick(); tick();

    // slave error routed to master 1 only
    tick(); lat = 0; err_mode = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 32'h55);
    neg();
    tick(); neg();
    chk("te_err", 32'(m_err_o), 32'h2);
    chk("te_ack", 32'(m_ack_o), 32'h0);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    err_mode = 1'b0;
    neg(); tick();

    // reset, then simultaneous requests and a multi-beat tenure
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    neg(); chk("t2_grant_c0", 32'(grant_o), 32'h0);
    tick(); neg();
    chk("t2_grant_c1", 32'(grant_o), 32'h1);
    chk("t2_ack_c1", 32'(m_ack_o), 32'h1);
    chk("t2_rdata_m0", m_dat_o, 32'hC0DE_0030);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); chk("t2_grant_c2", 32'(grant_o), 32'h1);
    tick(); neg(); chk("t2_grant_c3", 32'(grant_o), 32'h0);
    tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0);
    neg();
    chk("t2_grant_c4", 32'(grant_o), 32'h2);
    chk("t3_ack_0", 32'(m_ack_o), 32'h2);
    chk("t3_rdata_0", m_dat_o, 32'hC0DE_0020);
    for (int i = 0; i < 3; i++) begin
      tick(); adr_m[1] = rd_adr[i];
      neg();
      chk("t3_grant", 32'(grant_o), 32'h2);
      chk("t3_ack", 32'(m_ack_o), 32'h2);
      chk("t3_rdata", m_dat_o, rd_exp[i]);
    end
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); chk("t3_grant_drop", 32'(grant_o), 32'h2);
    tick(); drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0);
    neg(); chk("t3_grant_idle", 32'(grant_o), 32'h0);
    tick(); neg();
    chk("t3_rr_m0", 32'(grant_o), 32'h1);
    chk("t3_adr_m0", s_adr_o, 32'h34);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); tick(); neg();
    tick(); neg(); chk("t3_rr_m1", 32'(grant_o), 32'h2);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); tick();

    // watchdog abort with slave never responding
    tick(); lat = -1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h60, 32'h11);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h70, 32'h22);
    neg();
    for (int i = 0; i <= TO; i++) begin
      tick(); neg();
      chk("t4_timeout", 32'(timeout_o), (i == TO) ? 32'h1 : 32'h0);
      chk("t4_err", 32'(m_err_o), (i == TO) ? 32'h1 : 32'h0);
      chk("t4_s_cyc", 32'(s_cyc_o), (i == TO) ? 32'h0 : 32'h1);
      chk("t4_grant", 32'(grant_o), 32'h1);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); lat = 0;
    neg(); chk("t4_grant_idle", 32'(grant_o), 32'h0);
    tick(); neg();
    chk("t4_next_grant", 32'(grant_o), 32'h2);
    chk("t4_next_ack", 32'(m_ack_o), 32'h2);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); tick();
    tick(); drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h64, 32'h33);
    neg(); tick(); neg();
    chk("t4b_ack", 32'(m_ack_o), 32'h1);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); tick();

    // reset in the middle of a tenure
    tick(); lat = -1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
    neg();
    tick(); neg();
    chk("t5_grant_busy", 32'(grant_o), 32'h1);
    tick(); rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h90, 32'h0);
    neg();
    chk("t5_rst_grant", 32'(grant_o), 32'h0);
    chk("t5_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("t5_rst_s_adr", s_adr_o, 32'h0);
    tick(); rst_n = 1'b1;
    neg();
    chk("t5_post_grant", 32'(grant_o), 32'h0);
    chk("t5_post_s_stb", 32'(s_stb_o), 32'h0);
    tick(); neg();
    chk("t5_prio_m0", 32'(grant_o), 32'h1);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); lat = 0;
    neg(); tick(); neg(); tick(); neg();
    chk("t5_then_m1", 32'(grant_o), 32'h2);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    neg(); tick(); neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached t=%0t", $time);
    $fatal(1, "time limit");
  end

endmodule
